pipeexe_mdu: RTL and testbench
==============================

// Module: pipeexe_mdu
// PURPOSE
//  ID/EXE pipeline register plus EXE stage of the 5-stage MIPS pipeline; consumes pipeid outputs.
//  Single-cycle ALU ops pass through in one cycle.
//  MULT/MULTU/DIV/DIVU run on an iterative shift-add/restoring engine into HI/LO.
//  Asserts ebusy to freeze IF/ID while the engine runs.
// PARAMETERS
//  MUL_FAST  0             1: multiply completes in one RUN cycle (uses *); 0: 32-step iterative
//  DIV0_LO   32'hFFFFFFFF  LO value written on divide-by-zero
// PORTS
//  clk       in   1   pipeline clock, all state on rising edge
//  clrn      in   1   asynchronous active-low reset
//  dwreg,dm2reg,dwmem,daluimm,dshift,djal  in 1  ID control bits (pipeid wreg..jal)
//  daluc     in   5   ID ALU opcode
//  da,db,dimm,dpc4  in  32  ID operands (already forwarded), immediate, PC+4
//  drn       in   5   ID destination register
//  dbubble   in   1   ID load-use stall (pipeid load_depen): load a bubble into E
//  ewreg,em2reg  out 1  E-stage controls as held in E reg (for pipeid hazard logic)
//  ern       out  5   E-stage destination register
//  mwreg_o,mwmem_o,mm2reg_o  out 1  controls passed to EXE/MEM reg; forced 0 while ebusy
//  ealu      out  32  EXE result
//  eb        out  32  store data (E-reg b)
//  ebusy     out  1   stall request: hold PC, IF/ID and E reg
// BEHAVIOUR
//  Reset (clrn=0, async): E reg all 0 (a NOP), state IDLE, cnt=0, HI=LO=0, ebusy=0, outputs 0.
//  E reg update per edge: ebusy=1 -> hold; else dbubble=1 -> bubble (wreg/m2reg/wmem=0, aluc=ADD);
//   else load d* fields. ebusy has priority over dbubble.
//  aluc: 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 XOR, 00101 LUI(b<<16),
//   00110 SLL, 00111 SRL, 01000 SRA (b by a[4:0]), 01001 SLT, 01010 SLTU,
//   10000 MULT, 10001 MULTU, 10010 DIV, 10011 DIVU, 10100 MFHI, 10101 MFLO,
//   10110 MTHI, 10111 MTLO; others -> ealu=0.
//  Operands: opa = eshift ? {27'b0,eimm[10:6]} : ea; opb = ealuimm ? eimm : eb.
//  ejal=1 -> ealu = epc4+4 (overrides aluc). ADD/SUB wrap mod 2^32, no overflow trap.
//  MTHI/MTLO write HI/LO at end of their E cycle; MFHI/MFLO read current HI/LO.
//  FSM (mdu op = aluc 100xx in E):
//   IDLE: mdu op -> latch |opa|,|opb| (unsigned ops: raw), signs; -> RUN, cnt=0.
//   RUN: one step/cycle; cnt==31 (MUL_FAST: first cycle for multiply) -> write HI/LO, -> DONE.
//   DONE: -> IDLE.
//  ebusy = mdu op in E && state!=DONE.
//   Occupancy: 34 cycles (1 IDLE + 32 RUN + 1 DONE); 3 with MUL_FAST multiply.
//  MULT: {HI,LO} = 64-bit product; signed result negated if signs differ.
//  DIV: LO = quotient, HI = remainder; truncating.
//   Quotient negated if signs differ; remainder takes dividend sign.
//  Divide by zero: HI=dividend, LO=DIV0_LO; still takes full latency.
//  Boundaries:
//   DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
//   MFHI directly after MULT sees new HI (written before DONE cycle ends).
//   Back-to-back MULTs: second enters at DONE edge and starts from IDLE.
//   Reset mid-RUN aborts; HI/LO=0.
//   mwreg_o/mwmem_o/mm2reg_o = E-reg bits & !ebusy, so MEM sees bubbles during the stall.
//   ern/ewreg remain live for hazard checks.
// TESTING
//  T1 reset: clrn=0 mid-DIV -> ebusy=0, HI=LO=0, mwreg_o=0 same cycle.
//  T2 ALU: ADD da=7,db=0xFFFFFFFF -> ealu=6; SRA shift sa=4,db=0x80000000 -> 0xF8000000.
//  T3 MULT -3*5 -> ebusy high 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1; MFLO next -> 0xFFFFFFF1.
//  T4 DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> HI=7, LO=DIV0_LO.
//  T5 dbubble=1 with ebusy=0 -> next E is NOP (ewreg=0); with ebusy=1 -> E held unchanged.
//  T6 jal: dpc4=0x100, djal=1 -> ealu=0x104; MULT then MULT: each 34-cycle occupancy, no lost op.

Source files
------------

// File: rtl/pipeexe_mdu_if.sv
// ID-to-EXE bundle: ID-stage fields in, E-stage results and hazard/stall info out.
// Handshake: there is no valid/ready pair; ebusy=1 tells ID to hold its fields and E to keep its contents.
interface pipeexe_mdu_if;
  logic        dwreg, dm2reg, dwmem, daluimm, dshift, djal;
  logic [4:0]  daluc;
  logic [31:0] da, db, dimm, dpc4;
  logic [4:0]  drn;
  logic        dbubble;
  logic        ewreg, em2reg;
  logic [4:0]  ern;
  logic        mwreg_o, mwmem_o, mm2reg_o;
  logic [31:0] ealu, eb;
  logic        ebusy;

  modport master (
    output dwreg, dm2reg, dwmem, daluimm, dshift, djal, daluc, da, db, dimm, dpc4, drn, dbubble,
    input  ewreg, em2reg, ern, mwreg_o, mwmem_o, mm2reg_o, ealu, eb, ebusy
  );
  modport slave (
    input  dwreg, dm2reg, dwmem, daluimm, dshift, djal, daluc, da, db, dimm, dpc4, drn, dbubble,
    output ewreg, em2reg, ern, mwreg_o, mwmem_o, mm2reg_o, ealu, eb, ebusy
  );
endinterface

// File: rtl/pipeexe_mdu.sv
// ID/EXE pipeline register and EXE stage of a 5-stage MIPS pipeline, with an
// iterative shift-add multiplier / restoring divider writing HI/LO.
module pipeexe_mdu #(
  parameter bit          MUL_FAST = 1'b0,
  parameter logic [31:0] DIV0_LO  = 32'hFFFF_FFFF
) (
  input  logic         clk,
  input  logic         clrn,
  pipeexe_mdu_if.slave bus,
  output logic [1:0]   state_o
);
  localparam logic [4:0] OP_ADD  = 5'b00000, OP_SUB  = 5'b00001, OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011, OP_XOR  = 5'b00100, OP_LUI  = 5'b00101;
  localparam logic [4:0] OP_SLL  = 5'b00110, OP_SRL  = 5'b00111, OP_SRA  = 5'b01000;
  localparam logic [4:0] OP_SLT  = 5'b01001, OP_SLTU = 5'b01010;
  localparam logic [4:0] OP_MFHI = 5'b10100, OP_MFLO = 5'b10101;
  localparam logic [4:0] OP_MTHI = 5'b10110, OP_MTLO = 5'b10111;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_e;

  logic        ewreg_q, em2reg_q, ewmem_q, ealuimm_q, eshift_q, ejal_q;
  logic [4:0]  ealuc_q, ern_q;
  logic [31:0] ea_q, eb_q, eimm_q, epc4_q;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [64:0] acc_q, acc_d;
  logic [31:0] dvs_q, dvs_d, hi_q, hi_d, lo_q, lo_d;
  logic        neg_q, neg_d, sgna_q, sgna_d, ismul_q, ismul_d;

  logic [31:0] opa, opb, alu_r;
  logic        is_mdu, ebusy, sgn_a, sgn_b;
  logic [32:0] mul_upper, div_trem;
  logic        div_ge;
  logic [64:0] step_acc;
  logic [63:0] fast_prod, prod;

  assign opa    = eshift_q ? {27'b0, eimm_q[10:6]} : ea_q;
  assign opb    = ealuimm_q ? eimm_q : eb_q;
  assign is_mdu = (ealuc_q[4:2] == 3'b100);
  assign ebusy  = is_mdu && (state_q != S_DONE);
  // Even opcodes (MULT, DIV) are the signed forms.
  assign sgn_a  = ~ealuc_q[0] & opa[31];
  assign sgn_b  = ~ealuc_q[0] & opb[31];

  // E register: a stall holds it; a load-use bubble loads an all-zero NOP (aluc = ADD).
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      {ewreg_q, em2reg_q, ewmem_q, ealuimm_q, eshift_q, ejal_q} <= '0;
      ealuc_q <= '0; ern_q <= '0;
      ea_q <= '0; eb_q <= '0; eimm_q <= '0; epc4_q <= '0;
    end else if (!ebusy) begin
      if (bus.dbubble) begin
        {ewreg_q, em2reg_q, ewmem_q, ealuimm_q, eshift_q, ejal_q} <= '0;
        ealuc_q <= OP_ADD; ern_q <= '0;
        ea_q <= '0; eb_q <= '0; eimm_q <= '0; epc4_q <= '0;
      end else begin
        ewreg_q   <= bus.dwreg;   em2reg_q <= bus.dm2reg; ewmem_q <= bus.dwmem;
        ealuimm_q <= bus.daluimm; eshift_q <= bus.dshift; ejal_q  <= bus.djal;
        ealuc_q   <= bus.daluc;   ern_q    <= bus.drn;
        ea_q <= bus.da; eb_q <= bus.db; eimm_q <= bus.dimm; epc4_q <= bus.dpc4;
      end
    end
  end

  // One engine step. Multiply: acc = {carry+upper, multiplier} shifted right.
  // Divide: acc[63:32] = partial remainder, acc[31:0] = dividend shifting into quotient.
  always_comb begin
    mul_upper = acc_q[64:32] + (acc_q[0] ? {1'b0, dvs_q} : 33'd0);
    div_trem  = {acc_q[63:32], acc_q[31]};
    div_ge    = (div_trem >= {1'b0, dvs_q});
    if (ismul_q) step_acc = {1'b0, mul_upper, acc_q[31:1]};
    else step_acc = {1'b0, (div_ge ? 32'(div_trem - {1'b0, dvs_q}) : div_trem[31:0]),
                     acc_q[30:0], div_ge};
    fast_prod = {32'b0, acc_q[31:0]} * {32'b0, dvs_q};
    prod      = MUL_FAST ? fast_prod : step_acc[63:0];
  end

  always_comb begin
    state_d = state_q; cnt_d = cnt_q; acc_d = acc_q; dvs_d = dvs_q;
    neg_d = neg_q; sgna_d = sgna_q; ismul_d = ismul_q;
    hi_d = hi_q; lo_d = lo_q;
    case (state_q)
      S_IDLE: if (is_mdu) begin
        state_d = S_RUN;
        cnt_d   = '0;
        acc_d   = {33'b0, (sgn_a ? -opa : opa)};
        dvs_d   = sgn_b ? -opb : opb;
        neg_d   = sgn_a ^ sgn_b;
        sgna_d  = sgn_a;
        ismul_d = ~ealuc_q[1];
      end
      S_RUN: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 5'd1;
        if ((cnt_q == 5'd31) || (MUL_FAST && ismul_q)) begin
          state_d = S_DONE;
          if (ismul_q) begin
            {hi_d, lo_d} = neg_q ? -prod : prod;
          end else if (dvs_q == 32'd0) begin
            hi_d = opa;
            lo_d = DIV0_LO;
          end else begin
            lo_d = neg_q  ? -step_acc[31:0]  : step_acc[31:0];
            hi_d = sgna_q ? -step_acc[63:32] : step_acc[63:32];
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (ealuc_q == OP_MTHI) hi_d = opa;
    if (ealuc_q == OP_MTLO) lo_d = opa;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= S_IDLE; cnt_q <= '0; acc_q <= '0; dvs_q <= '0;
      neg_q <= 1'b0; sgna_q <= 1'b0; ismul_q <= 1'b0;
      hi_q <= '0; lo_q <= '0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; acc_q <= acc_d; dvs_q <= dvs_d;
      neg_q <= neg_d; sgna_q <= sgna_d; ismul_q <= ismul_d;
      hi_q <= hi_d; lo_q <= lo_d;
    end
  end

  always_comb begin
    alu_r = '0;
    case (ealuc_q)
      OP_ADD:           alu_r = opa + opb;
      OP_SUB:           alu_r = opa - opb;
      OP_AND:           alu_r = opa & opb;
      OP_OR:            alu_r = opa | opb;
      OP_XOR:           alu_r = opa ^ opb;
      OP_LUI:           alu_r = {opb[15:0], 16'b0};
      OP_SLL:           alu_r = opb << opa[4:0];
      OP_SRL:           alu_r = opb >> opa[4:0];
      OP_SRA:           alu_r = $unsigned($signed(opb) >>> opa[4:0]);
      OP_SLT:           alu_r = {31'b0, ($signed(opa) < $signed(opb))};
      OP_SLTU:          alu_r = {31'b0, (opa < opb)};
      OP_MFHI:          alu_r = hi_q;
      OP_MFLO:          alu_r = lo_q;
      OP_MTHI, OP_MTLO: alu_r = opa;
      default:          alu_r = '0;
    endcase
    if (ejal_q) alu_r = epc4_q + 32'd4;
  end

  assign bus.ewreg    = ewreg_q;
  assign bus.em2reg   = em2reg_q;
  assign bus.ern      = ern_q;
  assign bus.mwreg_o  = ewreg_q  & ~ebusy;
  assign bus.mwmem_o  = ewmem_q  & ~ebusy;
  assign bus.mm2reg_o = em2reg_q & ~ebusy;
  assign bus.ealu     = alu_r;
  assign bus.eb       = eb_q;
  assign bus.ebusy    = ebusy;
  assign state_o      = state_q;
endmodule

// File: tb/tb_pipeexe_mdu.sv
// Directed + randomized bench for pipeexe_mdu against an arithmetic reference model.
module tb_pipeexe_mdu;
  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;
  localparam logic [4:0] A_ADD  = 5'h00, A_SUB  = 5'h01, A_AND  = 5'h02, A_OR   = 5'h03;
  localparam logic [4:0] A_XOR  = 5'h04, A_LUI  = 5'h05, A_SLL  = 5'h06, A_SRL  = 5'h07;
  localparam logic [4:0] A_SRA  = 5'h08, A_SLT  = 5'h09, A_SLTU = 5'h0A;
  localparam logic [4:0] A_MULT = 5'h10, A_MULTU = 5'h11, A_DIV = 5'h12, A_DIVU = 5'h13;
  localparam logic [4:0] A_MFHI = 5'h14, A_MFLO = 5'h15, A_MTHI = 5'h16, A_MTLO = 5'h17;

  logic        clk = 1'b0;
  logic        clrn;
  logic [1:0]  state;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] exp_q[$];

  pipeexe_mdu_if bus();
  pipeexe_mdu #(.MUL_FAST(1'b0), .DIV0_LO(DIV0_LO)) dut (
    .clk(clk), .clrn(clrn), .bus(bus), .state_o(state)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [4:0] aluc, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [4:0] rn, input logic wreg,
                       input logic shift, input logic aluimm);
    bus.daluc = aluc; bus.da = a; bus.db = b; bus.dimm = imm; bus.drn = rn;
    bus.dwreg = wreg; bus.dm2reg = 1'b0; bus.dwmem = 1'b0;
    bus.daluimm = aluimm; bus.dshift = shift; bus.djal = 1'b0; bus.dpc4 = '0;
    bus.dbubble = 1'b0;
  endtask

  task automatic set_nop();
    set_d(A_ADD, '0, '0, '0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_alu(input logic [4:0] aluc, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] imm,
                                          input logic shift, input logic aluimm);
    logic [31:0] x, y;
    int unsigned sh;
    x  = shift ? ((imm >> 6) & 32'h1F) : a;
    y  = aluimm ? imm : b;
    sh = x % 32;
    case (aluc)
      A_ADD:   return x + y;
      A_SUB:   return x - y;
      A_AND:   return x & y;
      A_OR:    return x | y;
      A_XOR:   return x ^ y;
      A_LUI:   return y * 32'd65536;
      A_SLL:   return y << sh;
      A_SRL:   return y >> sh;
      A_SRA:   return 32'($signed(y) >>> sh);
      A_SLT:   return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      A_SLTU:  return (x < y) ? 32'd1 : 32'd0;
      A_MFHI:  return m_hi;
      A_MFLO:  return m_lo;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_mdu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sq, sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      A_MULT:  begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
      A_MULTU: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      A_DIV: begin
        if (b == 32'd0) begin m_hi = a; m_lo = DIV0_LO; end
        else begin sq = sa / sb; sr = sa % sb; m_lo = sq[31:0]; m_hi = sr[31:0]; end
      end
      A_DIVU: begin
        if (b == 32'd0) begin m_hi = a; m_lo = DIV0_LO; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
      default: ;
    endcase
  endtask

  // Issue one MDU op, measure its stall, then read LO and HI back via MFLO/MFHI.
  // With bub=1, ID presents a load-use bubble throughout the stall.
  task automatic do_mdu(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit bub);
    int busy;
    model_mdu(op, a, b);
    exp_q.push_back(m_lo);
    exp_q.push_back(m_hi);
    set_d(op, a, b, '0, 5'd9, 1'b1, 1'b0, 1'b0);
    tick();
    if (bub) begin
      set_d(A_ADD, 32'd1, 32'd2, '0, 5'd20, 1'b1, 1'b0, 1'b0);
      bus.dbubble = 1'b1;
    end else begin
      set_d(A_MFLO, '0, '0, '0, 5'd3, 1'b1, 1'b0, 1'b0);
    end
    busy = 0;
    while (bus.ebusy === 1'b1 && busy < 100) begin
      if (busy == 5) begin
        chk({tag, "_mwreg_stall"}, {31'b0, bus.mwreg_o}, 32'd0);
        chk({tag, "_ern_held"},    {27'b0, bus.ern}, 32'd9);
        chk({tag, "_ewreg_live"},  {31'b0, bus.ewreg}, 32'd1);
      end
      busy++;
      tick();
    end
    chk({tag, "_busy_cycles"}, busy, 32'd33);
    chk({tag, "_mwreg_done"}, {31'b0, bus.mwreg_o}, 32'd1);
    tick();
    if (bub) begin
      chk({tag, "_bubble_ewreg"},  {31'b0, bus.ewreg}, 32'd0);
      chk({tag, "_bubble_em2reg"}, {31'b0, bus.em2reg}, 32'd0);
      set_d(A_MFLO, '0, '0, '0, 5'd3, 1'b1, 1'b0, 1'b0);
      tick();
    end
    chk({tag, "_lo"}, bus.ealu, exp_q.pop_front());
    set_d(A_MFHI, '0, '0, '0, 5'd4, 1'b1, 1'b0, 1'b0);
    tick();
    chk({tag, "_hi"}, bus.ealu, exp_q.pop_front());
    set_nop();
  endtask

  logic [4:0] alu_ops [16] = '{A_ADD, A_SUB, A_AND, A_OR, A_XOR, A_LUI, A_SLL, A_SRL,
                               A_SRA, A_SLT, A_SLTU, A_MFHI, A_MFLO, A_MTHI, A_MTLO, 5'h18};

  // ---------------- directed and random steps ----------------
  initial begin
    logic [4:0]  op;
    logic [31:0] a, b, imm;
    logic        sh, ai, wr;
    logic [4:0]  rn;
    int          busy1, busy2, r;

    clrn = 1'b0;
    set_nop();
    #1;
    chk("rst_ebusy", {31'b0, bus.ebusy}, 32'd0);
    chk("rst_ewreg", {31'b0, bus.ewreg}, 32'd0);
    chk("rst_mwreg", {31'b0, bus.mwreg_o}, 32'd0);
    chk("rst_ealu",  bus.ealu, 32'd0);
    chk("rst_state", {30'b0, state}, 32'd0);
    repeat (2) tick();
    clrn = 1'b1;

    set_d(A_ADD, 32'd7, 32'hFFFF_FFFF, '0, 5'd1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("add_wrap", bus.ealu, 32'd6);
    chk("add_mwreg", {31'b0, bus.mwreg_o}, 32'd1);
    set_d(A_SRA, '0, 32'h8000_0000, 32'd4 << 6, 5'd2, 1'b1, 1'b1, 1'b0);
    tick();
    chk("sra_sa4", bus.ealu, 32'hF800_0000);

    set_d(A_ADD, '0, '0, '0, 5'd31, 1'b1, 1'b0, 1'b0);
    bus.djal = 1'b1;
    bus.dpc4 = 32'h100;
    tick();
    chk("jal_pc8", bus.ealu, 32'h104);

    set_d(A_ADD, 32'd3, 32'd4, '0, 5'd7, 1'b1, 1'b0, 1'b0);
    bus.dbubble = 1'b1;
    tick();
    chk("bubble_ewreg", {31'b0, bus.ewreg}, 32'd0);
    chk("bubble_mwreg", {31'b0, bus.mwreg_o}, 32'd0);

    for (int i = 0; i < 48; i++) begin
      op  = alu_ops[$urandom_range(0, 15)];
      a   = $urandom;
      b   = $urandom;
      imm = $urandom;
      sh  = 1'($urandom_range(0, 1));
      ai  = 1'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1));
      rn  = 5'($urandom_range(0, 31));
      set_d(op, a, b, imm, rn, wr, sh, ai);
      tick();
      if (op != A_MTHI && op != A_MTLO) chk("alu_rand", bus.ealu, ref_alu(op, a, b, imm, sh, ai));
      chk("rand_ern", {27'b0, bus.ern}, {27'b0, rn});
      chk("rand_mwreg", {31'b0, bus.mwreg_o}, {31'b0, wr});
      chk("rand_eb", bus.eb, b);
      if (op == A_MTHI) m_hi = sh ? ((imm >> 6) & 32'h1F) : a;
      if (op == A_MTLO) m_lo = sh ? ((imm >> 6) & 32'h1F) : a;
    end
    set_nop();
    tick();

    do_mdu("mult_m3x5", A_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0);
    do_mdu("div_m7d2", A_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
    do_mdu("divu_7d0", A_DIVU, 32'd7, 32'd0, 1'b0);
    do_mdu("div_minm1", A_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("div_minm1_lo_const", m_lo, 32'h8000_0000);
    chk("div_minm1_hi_const", m_hi, 32'd0);

    for (int i = 0; i < 6; i++) begin
      op = A_MULT + 5'($urandom_range(0, 3));
      a  = $urandom;
      r  = $urandom_range(0, 3);
      b  = (r == 0) ? 32'd0 : (r == 1) ? 32'($urandom_range(1, 20)) : $urandom;
      do_mdu("mdu_rand", op, a, b, 1'($urandom_range(0, 1)));
    end

    // Back-to-back MULTs: the second is presented throughout the first's stall.
    model_mdu(A_MULT, 32'd1234, 32'hFFFF_0000);
    model_mdu(A_MULTU, 32'hDEAD_BEEF, 32'h1234_5678);
    set_d(A_MULT, 32'd1234, 32'hFFFF_0000, '0, 5'd9, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(A_MULTU, 32'hDEAD_BEEF, 32'h1234_5678, '0, 5'd10, 1'b0, 1'b0, 1'b0);
    busy1 = 0;
    while (bus.ebusy === 1'b1 && busy1 < 100) begin busy1++; tick(); end
    tick();
    set_d(A_MFLO, '0, '0, '0, 5'd3, 1'b1, 1'b0, 1'b0);
    busy2 = 0;
    while (bus.ebusy === 1'b1 && busy2 < 100) begin busy2++; tick(); end
    chk("b2b_busy1", busy1, 32'd33);
    chk("b2b_busy2", busy2, 32'd33);
    tick();
    chk("b2b_lo", bus.ealu, m_lo);
    set_d(A_MFHI, '0, '0, '0, 5'd4, 1'b1, 1'b0, 1'b0);
    tick();
    chk("b2b_hi", bus.ealu, m_hi);

    // Reset in the middle of a divide aborts it and clears HI/LO.
    set_d(A_DIV, 32'd100, 32'd7, '0, 5'd9, 1'b1, 1'b0, 1'b0);
    tick();
    set_nop();
    repeat (10) tick();
    chk("mid_div_busy", {31'b0, bus.ebusy}, 32'd1);
    clrn = 1'b0;
    #1;
    chk("rst_mid_ebusy", {31'b0, bus.ebusy}, 32'd0);
    chk("rst_mid_mwreg", {31'b0, bus.mwreg_o}, 32'd0);
    chk("rst_mid_ewreg", {31'b0, bus.ewreg}, 32'd0);
    chk("rst_mid_state", {30'b0, state}, 32'd0);
    tick();
    clrn = 1'b1;
    m_hi = '0;
    m_lo = '0;
    set_d(A_MFHI, '0, '0, '0, 5'd4, 1'b1, 1'b0, 1'b0);
    tick();
    chk("rst_hi_zero", bus.ealu, m_hi);
    set_d(A_MFLO, '0, '0, '0, 5'd4, 1'b1, 1'b0, 1'b0);
    tick();
    chk("rst_lo_zero", bus.ealu, m_lo);
    set_nop();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
